// File: rtl/iq_settle_detect_if.sv
// rtl/iq_settle_detect_if.sv - weight sample bus from the IQ compensator into the settle detector
interface iq_settle_detect_if #(
  parameter int W_WIDTH = 13
);
  logic                      enable;
  logic                      sample_valid;
  logic signed [W_WIDTH-1:0] Wr;
  logic signed [W_WIDTH-1:0] Wj;

  modport master (output enable, sample_valid, Wr, Wj);
  modport slave  (input  enable, sample_valid, Wr, Wj);
endinterface

// File: rtl/iq_settle_detect.sv
// rtl/iq_settle_detect.sv - windowed convergence detector that freezes the IQ compensator weights
module iq_settle_detect #(
  parameter int W_WIDTH         = 13,
  parameter int WIN_LOG2        = 6,
  parameter int TOL             = 16,
  parameter int HOLD_WINDOWS    = 4,
  parameter int TIMEOUT_WINDOWS = 255
) (
  input  logic                      clk,
  input  logic                      RESET,
  iq_settle_detect_if.slave         s,
  output logic                      freeze_iqcomp,
  output logic                      settled,
  output logic                      timeout,
  output logic signed [W_WIDTH-1:0] Wr_lock,
  output logic signed [W_WIDTH-1:0] Wj_lock,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRACK   = 2'd1,
    S_LOCKED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  localparam logic [W_WIDTH:0] TOL_V     = (W_WIDTH+1)'(TOL);
  localparam logic [3:0]       HOLD_V    = 4'(HOLD_WINDOWS);
  localparam logic [7:0]       TIMEOUT_V = 8'(TIMEOUT_WINDOWS);

  state_t                    state;
  logic [WIN_LOG2-1:0]       sample_cnt;
  logic [7:0]                win_cnt;
  logic [3:0]                stable_cnt;
  logic signed [W_WIDTH-1:0] min_r, max_r, min_j, max_j;

  logic                      first, win_end, win_stable;
  logic signed [W_WIDTH-1:0] nmin_r, nmax_r, nmin_j, nmax_j;
  logic [W_WIDTH:0]          span_r, span_j;
  logic [3:0]                stable_upd;
  logic [7:0]                win_upd;

  // Extremes including the current sample, so the window-ending sample counts
  always_comb begin
    first      = (sample_cnt == '0);
    win_end    = &sample_cnt;
    nmin_r     = (first || s.Wr < min_r) ? s.Wr : min_r;
    nmax_r     = (first || s.Wr > max_r) ? s.Wr : max_r;
    nmin_j     = (first || s.Wj < min_j) ? s.Wj : min_j;
    nmax_j     = (first || s.Wj > max_j) ? s.Wj : max_j;
    span_r     = {nmax_r[W_WIDTH-1], nmax_r} - {nmin_r[W_WIDTH-1], nmin_r};
    span_j     = {nmax_j[W_WIDTH-1], nmax_j} - {nmin_j[W_WIDTH-1], nmin_j};
    win_stable = (span_r <= TOL_V) && (span_j <= TOL_V);
    stable_upd = 4'd0;
    if (win_stable)
      stable_upd = (stable_cnt >= HOLD_V) ? HOLD_V : stable_cnt + 4'd1;
    win_upd    = win_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state         <= S_IDLE;
      sample_cnt    <= '0;
      win_cnt       <= '0;
      stable_cnt    <= '0;
      min_r         <= '0;
      max_r         <= '0;
      min_j         <= '0;
      max_j         <= '0;
      freeze_iqcomp <= 1'b0;
      settled       <= 1'b0;
      timeout       <= 1'b0;
      Wr_lock       <= '0;
      Wj_lock       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          freeze_iqcomp <= 1'b0;
          settled       <= 1'b0;
          timeout       <= 1'b0;
          if (s.enable) begin
            state      <= S_TRACK;
            sample_cnt <= '0;
            win_cnt    <= '0;
            stable_cnt <= '0;
          end
        end
        S_TRACK: begin
          if (!s.enable) begin
            state      <= S_IDLE;
            sample_cnt <= '0;
          end else if (s.sample_valid) begin
            min_r      <= nmin_r;
            max_r      <= nmax_r;
            min_j      <= nmin_j;
            max_j      <= nmax_j;
            sample_cnt <= sample_cnt + 1'b1;
            if (win_end) begin
              stable_cnt <= stable_upd;
              win_cnt    <= win_upd;
              // Lock is tested first so it wins over a coincident timeout
              if (stable_upd == HOLD_V) begin
                state         <= S_LOCKED;
                freeze_iqcomp <= 1'b1;
                settled       <= 1'b1;
                Wr_lock       <= s.Wr;
                Wj_lock       <= s.Wj;
              end else if (win_upd == TIMEOUT_V) begin
                state         <= S_TIMEOUT;
                freeze_iqcomp <= 1'b1;
                timeout       <= 1'b1;
                Wr_lock       <= s.Wr;
                Wj_lock       <= s.Wj;
              end
            end
          end
        end
        S_LOCKED, S_TIMEOUT: begin
          if (!s.enable) begin
            state         <= S_IDLE;
            freeze_iqcomp <= 1'b0;
            settled       <= 1'b0;
            timeout       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_iq_settle_detect.sv
// tb/tb_iq_settle_detect.sv - directed self-checking bench for iq_settle_detect
module tb_iq_settle_detect;
  localparam int W = 13;

  logic clk = 1'b0;
  logic RESET;
  logic freeze_iqcomp, settled, timeout;
  logic signed [W-1:0] Wr_lock, Wj_lock;
  logic [1:0] state_dbg;
  int checks = 0;
  int errors = 0;

  iq_settle_detect_if #(.W_WIDTH(W)) bus ();

  iq_settle_detect #(
    .W_WIDTH(W), .WIN_LOG2(2), .TOL(4), .HOLD_WINDOWS(2), .TIMEOUT_WINDOWS(8)
  ) dut (
    .clk(clk), .RESET(RESET), .s(bus.slave),
    .freeze_iqcomp(freeze_iqcomp), .settled(settled), .timeout(timeout),
    .Wr_lock(Wr_lock), .Wj_lock(Wj_lock), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit en, input bit vld, input int wr, input int wj);
    bus.enable       = en;
    bus.sample_valid = vld;
    bus.Wr           = W'(wr);
    bus.Wj           = W'(wj);
    tick();
  endtask

  task automatic check_flags(input string tag, input int fr, input int st, input int to, input int sd);
    check({tag, ".freeze"}, freeze_iqcomp, fr);
    check({tag, ".settled"}, settled, st);
    check({tag, ".timeout"}, timeout, to);
    check({tag, ".state"}, state_dbg, sd);
  endtask

  initial begin
    RESET = 1'b1;
    bus.enable = 1'b0; bus.sample_valid = 1'b0; bus.Wr = '0; bus.Wj = '0;
    tick(); tick();
    check_flags("reset", 0, 0, 0, 0);
    check("reset.wr_lock", Wr_lock, 0);
    check("reset.wj_lock", Wj_lock, 0);
    RESET = 1'b0;

    // Constant input locks after 2 windows of 4 samples
    push(1, 0, 0, 0);
    check("const.enter_track", state_dbg, 1);
    for (int i = 0; i < 8; i++) begin
      push(1, 1, 100, -50);
      if (i < 7) check("const.pre_lock", settled, 0);
    end
    check_flags("const.lock", 1, 1, 0, 2);
    check("const.wr_lock", Wr_lock, 100);
    check("const.wj_lock", Wj_lock, -50);
    push(0, 0, 0, 0);
    check_flags("const.drop", 0, 0, 0, 0);
    check("const.wr_hold", Wr_lock, 100);

    // Span of exactly TOL is still stable
    push(1, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      push(1, 1, (i % 2) ? 4 : 0, (i % 2) ? -4092 : -4096);
    check_flags("span4.lock", 1, 1, 0, 2);
    check("span4.wr_lock", Wr_lock, 4);
    check("span4.wj_lock", Wj_lock, -4092);
    push(0, 0, 0, 0);

    // Span of TOL+1 never locks and times out at window 8
    push(1, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      push(1, 1, (i % 2) ? 5 : 0, 0);
      if (i == 30) check_flags("span5.pre_to", 0, 0, 0, 1);
    end
    check_flags("span5.timeout", 1, 0, 1, 3);
    check("span5.wr_lock", Wr_lock, 5);
    push(0, 0, 0, 0);
    check_flags("span5.drop", 0, 0, 0, 0);

    // Gapped samples: lock counts accepted samples, not cycles
    push(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      push(1, (i % 2) == 0, 200, 7);
      check("gap.settled", settled, (i >= 14) ? 1 : 0);
    end
    check("gap.wr_lock", Wr_lock, 200);
    push(0, 0, 0, 0);

    // Unstable window 2 resets the hold count
    push(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      push(1, 1, (i == 5) ? 60 : (i == 15) ? 52 : 50, 0);
      if (i == 11) check_flags("broken.w3", 0, 0, 0, 1);
    end
    check_flags("broken.lock", 1, 1, 0, 2);
    check("broken.wr_lock", Wr_lock, 52);
    push(0, 0, 0, 0);

    // Early drop mid-window 2, then a fresh start
    push(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) push(1, 1, 30, 30);
    push(0, 1, 30, 30);
    check_flags("drop.idle", 0, 0, 0, 0);
    check("drop.wr_hold", Wr_lock, 52);
    push(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      push(1, 1, 30, 30);
      if (i == 3) check_flags("drop.fresh_w1", 0, 0, 0, 1);
    end
    check_flags("drop.relock", 1, 1, 0, 2);
    check("drop.wr_lock", Wr_lock, 30);

    // Reset while locked, enable still high
    RESET = 1'b1;
    push(1, 1, 30, 30);
    check_flags("rst_locked", 0, 0, 0, 0);
    check("rst_locked.wr_lock", Wr_lock, 0);
    check("rst_locked.wj_lock", Wj_lock, 0);
    RESET = 1'b0;
    push(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
